command_dispatcher: RTL and testbench

Consumes the opcode/data stream presented by the command processor during its EXECUTING phase, decodes each command, accumulates draw state in internal registers, and issues draw requests to the raster front end over a valid/accept handshake. It sits directly downstream of the command processor. It is the only agent driving the processor's command-request input.

---
 rtl/command_dispatcher_if.sv | 32 +++
 rtl/command_dispatcher.sv | 150 +++++++++++++++
 tb/tb_command_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/command_dispatcher_if.sv
// Command-stream and draw-request signals between the command processor,
// the dispatcher and the raster front end.
interface command_dispatcher_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   aCommandReady;
  logic [15:0]            aCommand;
  logic [15:0]            aCommandData;
  logic                   anOutCommandRequested;
  logic                   anOutDrawValid;
  logic [ADDR_WIDTH-1:0]  anOutDrawAddr;
  logic [COUNT_WIDTH-1:0] anOutDrawCount;
  logic [31:0]            anOutDrawColor;
  logic                   aDrawAccept;
  logic                   aDrawBusy;
  logic                   anOutBusy;
  logic                   anOutDone;
  logic                   anOutError;

  modport master (
    input  aCommandReady, aCommand, aCommandData, aDrawAccept, aDrawBusy,
    output anOutCommandRequested, anOutDrawValid, anOutDrawAddr,
           anOutDrawCount, anOutDrawColor, anOutBusy, anOutDone, anOutError
  );

  modport slave (
    output aCommandReady, aCommand, aCommandData, aDrawAccept, aDrawBusy,
    input  anOutCommandRequested, anOutDrawValid, anOutDrawAddr,
           anOutDrawCount, anOutDrawColor, anOutBusy, anOutDone, anOutError
  );
endinterface

// File: rtl/command_dispatcher.sv
// Decodes the command processor's opcode stream, accumulates draw state and
// issues draw requests to the raster front end over a valid/accept handshake.
module command_dispatcher #(
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input logic                  aClock,
  input logic                  aReset,
  command_dispatcher_if.master bus
);

  localparam logic [15:0] OP_NOP          = 16'h0000;
  localparam logic [15:0] OP_END          = 16'h0001;
  localparam logic [15:0] OP_SET_ADDR_LO  = 16'h0002;
  localparam logic [15:0] OP_SET_ADDR_HI  = 16'h0003;
  localparam logic [15:0] OP_SET_COUNT    = 16'h0004;
  localparam logic [15:0] OP_SET_COLOR_LO = 16'h0005;
  localparam logic [15:0] OP_SET_COLOR_HI = 16'h0006;
  localparam logic [15:0] OP_DRAW         = 16'h0007;
  localparam logic [15:0] OP_WAIT_IDLE    = 16'h0008;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DRAW,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [15:0]            r_cmd;
  logic [15:0]            r_data;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [31:0]            r_color;
  logic                   r_error;
  logic                   w_req;
  logic                   w_valid;
  logic                   w_done;
  logic                   w_set_err;
  logic                   w_clr_err;

  // Upper address bits come from the operand, truncated to the bus width.
  function automatic logic [ADDR_WIDTH-1:0] f_addr_hi(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [15:0]           d
  );
    logic [ADDR_WIDTH+15:0] t;
    t       = {{ADDR_WIDTH{1'b0}}, d} << 16;
    t[15:0] = a[15:0];
    return t[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_valid   = 1'b0;
    w_done    = 1'b0;
    w_set_err = 1'b0;
    w_clr_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.aCommandReady) begin
          w_next    = S_FETCH;
          w_clr_err = 1'b1;
        end
      end
      S_FETCH: begin
        if (bus.aCommandReady) begin
          w_req  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = S_FETCH;
        case (r_cmd)
          OP_NOP, OP_SET_ADDR_LO, OP_SET_ADDR_HI, OP_SET_COUNT,
          OP_SET_COLOR_LO, OP_SET_COLOR_HI: w_next = S_FETCH;
          OP_DRAW:      if (r_count != '0) w_next = S_DRAW;
          OP_WAIT_IDLE: w_next = S_WAIT;
          OP_END: begin
            w_done = 1'b1;
            w_next = S_DONE;
          end
          default:      w_set_err = 1'b1;
        endcase
      end
      S_DRAW: begin
        w_valid = 1'b1;
        if (bus.aDrawAccept) w_next = S_FETCH;
      end
      S_WAIT: begin
        if (!bus.aDrawBusy) w_next = S_FETCH;
      end
      // Leaving only once the processor drops ready avoids re-fetching past END.
      S_DONE: begin
        if (!bus.aCommandReady) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aClock) begin
    if (aReset) begin
      r_state <= S_IDLE;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clr_err)      r_error <= 1'b0;
      else if (w_set_err) r_error <= 1'b1;
    end
  end

  always_ff @(posedge aClock) begin
    if (r_state == S_FETCH && bus.aCommandReady) begin
      r_cmd  <= bus.aCommand;
      r_data <= bus.aCommandData;
    end
  end

  // Draw state only changes in DECODE, so it is frozen while a draw is offered.
  always_ff @(posedge aClock) begin
    if (aReset) begin
      r_addr  <= '0;
      r_count <= '0;
      r_color <= '0;
    end else if (r_state == S_DECODE) begin
      case (r_cmd)
        OP_SET_ADDR_LO:  r_addr[15:0]   <= r_data;
        OP_SET_ADDR_HI:  r_addr         <= f_addr_hi(r_addr, r_data);
        OP_SET_COUNT:    r_count        <= COUNT_WIDTH'(r_data);
        OP_SET_COLOR_LO: r_color[15:0]  <= r_data;
        OP_SET_COLOR_HI: r_color[31:16] <= r_data;
        default: ;
      endcase
    end
  end

  assign bus.anOutCommandRequested = w_req;
  assign bus.anOutDrawValid        = w_valid;
  assign bus.anOutDrawAddr         = r_addr;
  assign bus.anOutDrawCount        = r_count;
  assign bus.anOutDrawColor        = r_color;
  assign bus.anOutBusy             = (r_state != S_IDLE);
  assign bus.anOutDone             = w_done;
  assign bus.anOutError            = r_error;

endmodule

// File: tb/tb_command_dispatcher.sv
// Randomized scoreboard bench for command_dispatcher: a command-processor
// model feeds lists, a reference model predicts draws, request timing and flags.
module tb_command_dispatcher;
  localparam int AW  = 32;
  localparam int CW  = 16;
  localparam int INF = 1 << 30;
  localparam logic [15:0] OP_NOP = 16'h0000, OP_END = 16'h0001;
  localparam logic [15:0] OP_ALO = 16'h0002, OP_AHI = 16'h0003;
  localparam logic [15:0] OP_CNT = 16'h0004, OP_CLO = 16'h0005;
  localparam logic [15:0] OP_CHI = 16'h0006, OP_DRAW = 16'h0007;
  localparam logic [15:0] OP_WAIT = 16'h0008;
  localparam int K_PLAIN = 0, K_DRAW = 1, K_WAIT = 2, K_END = 3;

  typedef struct { logic [15:0] op; logic [15:0] data; } cmd_t;
  typedef struct { logic [AW-1:0] addr; logic [CW-1:0] count; logic [31:0] color; } draw_t;
  typedef struct { int kind; bit first; } expc_t;

  logic aClock = 1'b0;
  logic aReset = 1'b1;
  always #5 aClock = ~aClock;

  command_dispatcher_if #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();
  command_dispatcher #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .aClock(aClock), .aReset(aReset), .bus(bus.master)
  );

  cmd_t  cur_list[$];
  draw_t exp_draw_q[$];
  expc_t exp_cmd_q[$];
  int load_gen = 0, abort_gen = 0;
  int passed = 0, total = 0;
  int cyc = 0, busy_until = 0, acc_delay = 0, stall_pct = 0;
  int req_cnt = 0, done_cnt = 0, r0 = 0, d0 = 0;
  bit exp_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic [CW-1:0] m_count = '0;
  logic [31:0]   m_color = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic cmd_t mk(input logic [15:0] op, input logic [15:0] data);
    cmd_t c;
    c.op = op; c.data = data;
    return c;
  endfunction

  // Command processor model plus raster front end stimulus.
  initial begin
    int ptr, seen_load, seen_abort, vcnt;
    bit active, r_req;
    cmd_t list[$];
    ptr = 0; seen_load = 0; seen_abort = 0; vcnt = 0; active = 0;
    bus.aCommandReady = 1'b0; bus.aCommand = '0; bus.aCommandData = '0;
    bus.aDrawAccept = 1'b0; bus.aDrawBusy = 1'b0;
    forever begin
      @(negedge aClock);
      r_req = bus.anOutCommandRequested;
      @(posedge aClock);
      cyc++;
      #1;
      if (r_req) ptr++;
      if (seen_abort != abort_gen) begin seen_abort = abort_gen; active = 0; end
      if (seen_load != load_gen) begin seen_load = load_gen; list = cur_list; ptr = 0; active = 1; end
      if (active && ptr >= list.size()) active = 0;
      bus.aCommandReady = active && ($urandom_range(0, 99) >= stall_pct);
      if (ptr < list.size()) begin
        bus.aCommand = list[ptr].op; bus.aCommandData = list[ptr].data;
      end else begin
        bus.aCommand = '0; bus.aCommandData = '0;
      end
      if (bus.anOutDrawValid) vcnt++; else vcnt = 0;
      bus.aDrawAccept = bus.anOutDrawValid ? (vcnt > acc_delay) : ($urandom_range(0, 3) == 0);
      bus.aDrawBusy = (cyc < busy_until);
    end
  end

  // Monitor: pops expectations whenever the DUT requests, draws or finishes.
  initial begin
    bit prev_req, hold, draw_pend;
    int exp_next, end_cyc, c0;
    draw_t prev_d, got, e_d;
    expc_t e;
    prev_req = 0; hold = 0; draw_pend = 0; exp_next = INF; end_cyc = -10;
    forever begin
      @(negedge aClock);
      if (aReset) begin
        prev_req = 0; hold = 0; draw_pend = 0; exp_next = INF;
      end else begin
        if (bus.aCommandReady && cyc >= exp_next)
          check("req_when_due", bus.anOutCommandRequested, 1);
        if (bus.anOutCommandRequested) begin
          req_cnt++;
          check("req_not_back_to_back", prev_req, 0);
          check("req_has_entry", exp_cmd_q.size() != 0, 1);
          if (exp_cmd_q.size() != 0) begin
            e = exp_cmd_q.pop_front();
            if (e.first) check("error_cleared_at_start", bus.anOutError, 0);
            else check("req_not_early", cyc >= exp_next, 1);
            case (e.kind)
              K_DRAW: begin draw_pend = 1; exp_next = INF; end
              K_WAIT: begin
                c0 = cyc + 2;
                if (busy_until > c0) c0 = busy_until;
                exp_next = c0 + 1;
              end
              K_END: begin end_cyc = cyc; exp_next = INF; end
              default: exp_next = cyc + 2;
            endcase
          end
        end
        prev_req = bus.anOutCommandRequested;
        if (bus.anOutDone) begin
          done_cnt++;
          check("done_timing", cyc, end_cyc + 1);
        end
        if (bus.anOutDrawValid) begin
          got.addr = bus.anOutDrawAddr; got.count = bus.anOutDrawCount; got.color = bus.anOutDrawColor;
          if (hold) check("draw_stable", {got.addr, got.count, got.color},
                          {prev_d.addr, prev_d.count, prev_d.color});
          if (bus.aDrawAccept) begin
            check("draw_pending", draw_pend, 1);
            check("draw_in_queue", exp_draw_q.size() != 0, 1);
            if (exp_draw_q.size() != 0) begin
              e_d = exp_draw_q.pop_front();
              check("draw_addr", got.addr, e_d.addr);
              check("draw_count", got.count, e_d.count);
              check("draw_color", got.color, e_d.color);
            end
            draw_pend = 0; exp_next = cyc + 1; hold = 0;
          end else begin
            hold = 1; prev_d = got;
          end
        end else hold = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge aClock); #1;
    aReset = 1'b1;
    abort_gen++;
    @(posedge aClock);
    @(negedge aClock);
    check("rst_valid", bus.anOutDrawValid, 0);
    check("rst_req", bus.anOutCommandRequested, 0);
    check("rst_done", bus.anOutDone, 0);
    check("rst_busy", bus.anOutBusy, 0);
    check("rst_error", bus.anOutError, 0);
    check("rst_addr", bus.anOutDrawAddr, 0);
    check("rst_count", bus.anOutDrawCount, 0);
    check("rst_color", bus.anOutDrawColor, 0);
    exp_draw_q.delete(); exp_cmd_q.delete();
    m_addr = '0; m_count = '0; m_color = '0;
    @(posedge aClock); #1;
    aReset = 1'b0;
  endtask

  // Reference model: walk the list and predict every draw and the error flag.
  task automatic start_list(input cmd_t l[$]);
    draw_t d;
    exp_err = 0;
    for (int i = 0; i < l.size(); i++) begin
      expc_t e;
      e.first = (i == 0);
      e.kind  = K_PLAIN;
      case (l[i].op)
        OP_NOP: ;
        OP_END:  e.kind = K_END;
        OP_ALO:  m_addr  = (m_addr & ~AW'(32'hFFFF)) | AW'(l[i].data);
        OP_AHI:  m_addr  = (m_addr & AW'(32'hFFFF)) | (AW'(l[i].data) << 16);
        OP_CNT:  m_count = CW'(l[i].data);
        OP_CLO:  m_color = (m_color & 32'hFFFF0000) | {16'h0, l[i].data};
        OP_CHI:  m_color = (m_color & 32'h0000FFFF) | {l[i].data, 16'h0};
        OP_DRAW: if (m_count != 0) begin
          e.kind = K_DRAW;
          d.addr = m_addr; d.count = m_count; d.color = m_color;
          exp_draw_q.push_back(d);
        end
        OP_WAIT: e.kind = K_WAIT;
        default: exp_err = 1;
      endcase
      exp_cmd_q.push_back(e);
    end
    r0 = req_cnt; d0 = done_cnt;
    cur_list = l;
    @(posedge aClock); #1;
    load_gen++;
  endtask

  task automatic finish_list(input int n);
    bit fin;
    fin = 0;
    for (int i = 0; i < 600 && !fin; i++) begin
      @(negedge aClock); #1;
      if (done_cnt != d0 && !bus.anOutBusy) fin = 1;
    end
    check("list_finished", fin, 1);
    check("req_count", req_cnt - r0, n);
    check("done_count", done_cnt - d0, 1);
    check("draws_left", exp_draw_q.size(), 0);
    check("error_flag", bus.anOutError, exp_err);
    if (!fin) do_reset();
  endtask

  task automatic run_list(input cmd_t l[$]);
    start_list(l);
    finish_list(l.size());
  endtask

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.data = 16'($urandom);
    case ($urandom_range(0, 9))
      0: c.op = OP_NOP;
      1: c.op = OP_ALO;
      2: c.op = OP_AHI;
      3: c.op = OP_CNT;
      4: c.op = OP_CLO;
      5: c.op = OP_CHI;
      6: c.op = OP_WAIT;
      7: c.op = 16'($urandom_range(9, 65535));
      default: c.op = OP_DRAW;
    endcase
    if (c.op == OP_CNT) c.data = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom_range(1, 20));
    return c;
  endfunction

  initial begin
    cmd_t l[$];
    bit seen;
    do_reset();

    l = {};
    l.push_back(mk(OP_ALO, 16'h1000)); l.push_back(mk(OP_AHI, 16'h0002));
    l.push_back(mk(OP_CNT, 16'd3));    l.push_back(mk(OP_CLO, 16'hBEEF));
    l.push_back(mk(OP_CHI, 16'hDEAD)); l.push_back(mk(OP_DRAW, 16'h0));
    l.push_back(mk(OP_END, 16'h0));
    run_list(l);

    acc_delay = 10;
    l = {}; l.push_back(mk(OP_DRAW, 16'h0)); l.push_back(mk(OP_END, 16'h0));
    run_list(l);
    acc_delay = 0;

    l = {}; l.push_back(mk(OP_CNT, 16'h0)); l.push_back(mk(OP_DRAW, 16'h0)); l.push_back(mk(OP_END, 16'h0));
    run_list(l);

    busy_until = cyc + 9;
    l = {}; l.push_back(mk(OP_WAIT, 16'h0)); l.push_back(mk(OP_END, 16'h0));
    run_list(l);

    l = {}; l.push_back(mk(16'h00FF, 16'h0)); l.push_back(mk(OP_END, 16'h0));
    run_list(l);
    l = {}; l.push_back(mk(OP_NOP, 16'h0)); l.push_back(mk(OP_END, 16'h0));
    run_list(l);

    acc_delay = 1000;
    l = {}; l.push_back(mk(OP_CNT, 16'd5)); l.push_back(mk(OP_DRAW, 16'h0)); l.push_back(mk(OP_END, 16'h0));
    start_list(l);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge aClock);
      if (bus.anOutDrawValid) seen = 1;
    end
    check("valid_before_reset", seen, 1);
    do_reset();
    acc_delay = 0;
    l = {}; l.push_back(mk(OP_CNT, 16'd7)); l.push_back(mk(OP_CLO, 16'h1234));
    l.push_back(mk(OP_DRAW, 16'h0)); l.push_back(mk(OP_END, 16'h0));
    run_list(l);

    for (int n = 0; n < 40; n++) begin
      int len;
      stall_pct  = $urandom_range(0, 30);
      acc_delay  = $urandom_range(0, 4);
      busy_until = cyc + $urandom_range(0, 15);
      len = $urandom_range(1, 8);
      l = {};
      for (int k = 0; k < len; k++) l.push_back(rnd_cmd());
      l.push_back(mk(OP_END, 16'h0));
      run_list(l);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
